// File: rtl/fb_wb_stage_pkg.sv
// Shared Firebird pipeline constants: datapath width, writeback source codes
// and load funct3 encodings.
package fb_wb_stage_pkg;
  localparam int FB_32BITS = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

  localparam logic [2:0] FB_LB  = 3'd0;
  localparam logic [2:0] FB_LH  = 3'd1;
  localparam logic [2:0] FB_LW  = 3'd2;
  localparam logic [2:0] FB_LBU = 3'd4;
  localparam logic [2:0] FB_LHU = 3'd5;
endpackage

// File: rtl/fb_wb_stage_if.sv
// MEM->WB inputs and the register-file write / bypass outputs of the
// writeback stage. slave = the stage itself, master = whoever drives MEM.
interface fb_wb_stage_if
  import fb_wb_stage_pkg::*;
#(
  parameter int XLEN      = FB_32BITS,
  parameter int INSTRET_W = 64
);
  logic                 mem_valid;
  logic [4:0]           mem_rd;
  logic                 mem_rd_we;
  logic [1:0]           mem_wb_sel;
  logic [XLEN-1:0]      mem_alu_result;
  logic [XLEN-1:0]      mem_pc_plus4;
  logic [2:0]           mem_funct3;
  logic [XLEN-1:0]      dmem_rdata;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 byp_valid;
  logic [4:0]           byp_rd;
  logic [XLEN-1:0]      byp_data;
  logic                 load_misaligned;
  logic [INSTRET_W-1:0] instret;

  modport slave (
    input  mem_valid, mem_rd, mem_rd_we, mem_wb_sel, mem_alu_result,
           mem_pc_plus4, mem_funct3, dmem_rdata,
    output rf_we, rf_waddr, rf_wdata, byp_valid, byp_rd, byp_data,
           load_misaligned, instret
  );

  modport master (
    output mem_valid, mem_rd, mem_rd_we, mem_wb_sel, mem_alu_result,
           mem_pc_plus4, mem_funct3, dmem_rdata,
    input  rf_we, rf_waddr, rf_wdata, byp_valid, byp_rd, byp_data,
           load_misaligned, instret
  );
endinterface

// File: rtl/fb_load_align.sv
// Combinational load extractor: picks byte/halfword from an aligned word,
// sign/zero-extends, and flags misaligned accesses. Shared with the store path.
module fb_load_align
  import fb_wb_stage_pkg::*;
#(
  parameter int XLEN = FB_32BITS
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  // Unlisted funct3 codes fall through to the word path, including its check.
  always_comb begin
    data       = rdata;
    misaligned = (off != 2'b00);
    case (funct3)
      FB_LB:  begin data = {{(XLEN-8){byte_sel[7]}}, byte_sel};    misaligned = 1'b0;   end
      FB_LBU: begin data = {{(XLEN-8){1'b0}}, byte_sel};           misaligned = 1'b0;   end
      FB_LH:  begin data = {{(XLEN-16){half_sel[15]}}, half_sel};  misaligned = off[0]; end
      FB_LHU: begin data = {{(XLEN-16){1'b0}}, half_sel};          misaligned = off[0]; end
      default: ;
    endcase
  end
endmodule

// File: rtl/fb_wb_stage.sv
// Firebird writeback stage: MEM/WB register, load formatting, register-file
// write port, ID/EX bypass and retired-instruction counter.
module fb_wb_stage
  import fb_wb_stage_pkg::*;
#(
  parameter int XLEN      = FB_32BITS,
  parameter int INSTRET_W = 64
) (
  input logic          clk,
  input logic          reset,
  fb_wb_stage_if.slave wb
);
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic                 wb_rd_we;
  logic [1:0]           wb_wb_sel;
  logic [XLEN-1:0]      wb_alu_result;
  logic [XLEN-1:0]      wb_pc_plus4;
  logic [2:0]           wb_funct3;
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_rd_we      <= 1'b0;
      wb_wb_sel     <= WB_SEL_ALU;
      wb_alu_result <= '0;
      wb_pc_plus4   <= '0;
      wb_funct3     <= '0;
      instret_q     <= '0;
    end else begin
      wb_valid      <= wb.mem_valid;
      wb_rd         <= wb.mem_rd;
      wb_rd_we      <= wb.mem_rd_we;
      wb_wb_sel     <= wb.mem_wb_sel;
      wb_alu_result <= wb.mem_alu_result;
      wb_pc_plus4   <= wb.mem_pc_plus4;
      wb_funct3     <= wb.mem_funct3;
      if (wb_valid) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  logic [XLEN-1:0] ld_data;
  logic            ld_mis;

  fb_load_align #(.XLEN(XLEN)) u_align (
    .funct3     (wb_funct3),
    .off        (wb_alu_result[1:0]),
    .rdata      (wb.dmem_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // Reset gates the stage combinationally so an instruction caught in WB
  // during reset never reaches the register file.
  logic            live;
  logic            mis;
  logic            we;
  logic [XLEN-1:0] src;

  assign live = wb_valid & ~reset;
  assign mis  = live & (wb_wb_sel == WB_SEL_LOAD) & ld_mis;
  assign we   = live & wb_rd_we & (wb_rd != 5'd0) & ~mis & (wb_wb_sel != WB_SEL_RSVD);

  always_comb begin
    case (wb_wb_sel)
      WB_SEL_ALU:  src = wb_alu_result;
      WB_SEL_LOAD: src = ld_data;
      WB_SEL_PC4:  src = wb_pc_plus4;
      default:     src = '0;
    endcase
  end

  assign wb.rf_we           = we;
  assign wb.rf_waddr        = we ? wb_rd : 5'd0;
  assign wb.rf_wdata        = we ? src : '0;
  assign wb.byp_valid       = we;
  assign wb.byp_rd          = we ? wb_rd : 5'd0;
  assign wb.byp_data        = we ? src : '0;
  assign wb.load_misaligned = mis;
  assign wb.instret         = instret_q;
endmodule

// File: tb/tb_fb_wb_stage.sv
// Randomized + directed bench for fb_wb_stage against a behavioural model.
// The counter is narrowed so that wrap-around happens within the run.
module tb_fb_wb_stage;
  localparam int XLEN = 32;
  localparam int IW   = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fb_wb_stage_if #(.XLEN(XLEN), .INSTRET_W(IW)) bus ();
  fb_wb_stage #(.XLEN(XLEN), .INSTRET_W(IW)) dut (.clk(clk), .reset(reset), .wb(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what sits in WB, and how many instructions have left WB.
  bit          m_en = 0;
  bit          m_v;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [1:0]  m_sel;
  logic [31:0] m_alu, m_pc4;
  logic [2:0]  m_f3;
  logic [IW-1:0] m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_en = 1; m_v = 0; m_cnt = 0;
    end else begin
      if (m_v) m_cnt = m_cnt + 1'b1;
      m_v   = bus.mem_valid;
      m_rd  = bus.mem_rd;
      m_we  = bus.mem_rd_we;
      m_sel = bus.mem_wb_sel;
      m_alu = bus.mem_alu_result;
      m_pc4 = bus.mem_pc_plus4;
      m_f3  = bus.mem_funct3;
    end
  end

  function automatic bit misal(input logic [2:0] f3, input int off);
    if (f3 == 3'd0 || f3 == 3'd4) return 0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    v = longint'(w >> (8 * off));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
      3'd5: v = v % 65536;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (m_en) begin
      bit e_mis, e_we;
      logic [31:0] e_d;
      e_mis = 0; e_we = 0; e_d = 0;
      if (m_v && !reset) begin
        e_mis = (m_sel == 2'd1) && misal(m_f3, int'(m_alu[1:0]));
        e_we  = m_we && (m_rd != 0) && !e_mis && (m_sel != 2'd3);
        if (e_we)
          e_d = (m_sel == 2'd0) ? m_alu : (m_sel == 2'd2) ? m_pc4 :
                fmt(m_f3, int'(m_alu[1:0]), bus.dmem_rdata);
      end
      chk("m_we",   {bus.rf_we, bus.byp_valid}, {e_we, e_we});
      chk("m_addr", {bus.rf_waddr, bus.byp_rd}, e_we ? {m_rd, m_rd} : 10'd0);
      chk("m_data", {bus.rf_wdata, bus.byp_data}, {e_d, e_d});
      chk("m_mis",  bus.load_misaligned, e_mis);
      chk("m_cnt",  bus.instret, m_cnt);
    end
  end

  task automatic ins(input bit v, input logic [4:0] rd, input bit we, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    bus.mem_valid = v; bus.mem_rd = rd; bus.mem_rd_we = we; bus.mem_wb_sel = sel;
    bus.mem_alu_result = alu; bus.mem_pc_plus4 = pc4; bus.mem_funct3 = f3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push one instruction through MEM, then stop at mid-cycle of its WB slot.
  task automatic one(input bit v, input logic [4:0] rd, input bit we, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                     input logic [31:0] dm);
    ins(v, rd, we, sel, alu, pc4, f3);
    tick();
    bus.dmem_rdata = dm;
    ins(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1;
    bus.dmem_rdata = 0;
    ins(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_cnt", bus.instret, 0);

    one(1, 5, 1, 0, 32'h1234, 0, 3'd2, 0);
    chk("alu_we", bus.rf_we, 1);
    chk("alu_addr", bus.rf_waddr, 5);
    chk("alu_data", bus.rf_wdata, 32'h1234);
    tick(); @(negedge clk);
    chk("alu_cnt", bus.instret, 1);

    one(1, 7, 1, 1, 32'h103, 0, 3'd0, 32'h80FF_0000);
    chk("lb", bus.rf_wdata, 32'hFFFF_FF80);
    one(1, 7, 1, 1, 32'h103, 0, 3'd4, 32'h80FF_0000);
    chk("lbu", bus.rf_wdata, 32'h0000_0080);
    one(1, 7, 1, 1, 32'h102, 0, 3'd5, 32'h80FF_0000);
    chk("lhu", bus.rf_wdata, 32'h0000_80FF);

    one(1, 8, 1, 1, 32'h102, 0, 3'd2, 32'h1111_2222);
    chk("lw_mis", bus.load_misaligned, 1);
    chk("lw_we", bus.rf_we, 0);
    chk("lw_data", bus.rf_wdata, 0);
    tick(); @(negedge clk);
    chk("lw_cnt", bus.instret, 5);

    one(1, 0, 1, 0, 32'hDEAD, 0, 3'd2, 0);
    chk("x0_we", bus.rf_we, 0);
    chk("x0_byp", bus.byp_valid, 0);
    one(1, 1, 1, 2, 32'h50, 32'h104, 3'd2, 0);
    chk("jal", bus.rf_wdata, 32'h104);
    tick(); @(negedge clk);
    chk("jal_cnt", bus.instret, 7);

    ins(1, 3, 1, 0, 1, 0, 3'd2); tick();
    ins(0, 3, 1, 0, 2, 0, 3'd2); @(negedge clk); chk("alt0", bus.rf_we, 1);
    tick();
    ins(1, 3, 1, 0, 3, 0, 3'd2); @(negedge clk); chk("alt1", bus.rf_we, 0);
    tick();
    ins(0, 0, 0, 0, 0, 0, 0);    @(negedge clk); chk("alt2", bus.rf_we, 1);
    tick(); @(negedge clk);
    chk("alt_cnt", bus.instret, 9);

    one(1, 9, 1, 1, 32'h200, 0, 3'd2, 32'hCAFE_F00D);
    #2 reset = 1;
    #1 chk("rstwb_we", bus.rf_we, 0);
    tick(); reset = 0;
    @(negedge clk);
    chk("rstwb_cnt", bus.instret, 0);

    for (int i = 0; i < 40; i++) begin ins(1, 5'(i), 1, 0, i, 0, 3'd2); tick(); end
    ins(0, 0, 0, 0, 0, 0, 0); tick(); @(negedge clk);
    chk("cnt40", bus.instret, 40);
    for (int i = 0; i < 24; i++) begin ins(1, 5'(i), 1, 0, i, 0, 3'd2); tick(); end
    ins(0, 0, 0, 0, 0, 0, 0); tick(); @(negedge clk);
    chk("wrap", bus.instret, 0);

    for (int i = 0; i < 800; i++) begin
      ins($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
          $urandom_range(0, 4) != 0, 2'($urandom), $urandom, $urandom, 3'($urandom));
      bus.dmem_rdata = $urandom;
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 0;
    ins(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_wb_stage.md
Name: fb_wb_stage

Overview:
Writeback stage of the Firebird 5-stage pipeline. It holds the MEM/WB pipeline register and formats load data returned by the synchronous data memory. It selects the writeback source and drives the write port of the register file. It also exports a bypass for ID/EX, because the register file reads asynchronously and only commits on the posedge, and it counts retired instructions.

Parameters:
XLEN, 32, datapath width
INSTRET_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_valid  in  1  MEM stage holds a real instruction this cycle
mem_rd  in  5  destination register
mem_rd_we  in  1  instruction writes rd
mem_wb_sel  in  2  writeback source: 0 ALU, 1 load, 2 PC+4, 3 reserved
mem_alu_result  in  XLEN  ALU result; also the load address
mem_pc_plus4  in  XLEN  link value for JAL/JALR
mem_funct3  in  3  load type: LB=0, LH=1, LW=2, LBU=4, LHU=5
dmem_rdata  in  XLEN  aligned word from data memory, valid in the WB cycle (1-cycle sync RAM)
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  XLEN  register file write data
byp_valid  out  1  bypass valid (equals rf_we)
byp_rd  out  5  bypass register (equals rf_waddr)
byp_data  out  XLEN  bypass data (equals rf_wdata)
load_misaligned  out  1  WB holds a misaligned load; its write is suppressed
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- MEM/WB register captures all mem_* inputs on every posedge. No stall input: the upstream hazard unit injects bubbles via mem_valid=0.
- reset: wb_valid=0, instret=0. All outputs are then 0: rf_we, rf_waddr, rf_wdata, byp_*, load_misaligned.
- A reset asserted while an instruction sits in WB drops that instruction. No write occurs in the reset cycle and instret is not incremented.
- Latency:
  - Instruction in MEM at cycle N occupies WB in cycle N+1.
  - The register file write commits at the posedge ending N+1.
  - byp_* are combinational from the WB register and valid throughout N+1.
- Load formatting, using the byte offset off = wb_alu_result[1:0]:
  - LB/LBU: byte off, sign- or zero-extended.
  - LH/LHU: halfword off[1], sign- or zero-extended.
  - LW: full word.
  - Undefined funct3 values behave as LW.
- Misaligned load: LH/LHU with off[0]=1, or LW with off!=0.
  - Asserts load_misaligned and forces rf_we=0.
  - Still counts as retired.
- Source select:
  - 0 → ALU result.
  - 1 → formatted load data.
  - 2 → PC+4.
  - 3 → data 0, rf_we=0.
- rf_we = wb_valid & wb_rd_we & (wb_rd!=0) & !misaligned & (wb_wb_sel!=3).
  - A write to x0 must never be issued, because the register file does not reset or protect x0.
- When rf_we=0, rf_wdata, rf_waddr and byp_data are driven to 0, so no X leaks into the forwarding muxes.
- instret increments by 1 at the posedge ending each cycle with wb_valid=1. It wraps modulo 2^INSTRET_W.
- Back-to-back writes to the same rd in consecutive cycles: each cycle drives its own data, and the last one wins in the register file.

Decomposition:
- Shared package/defines gets:
  - FB_32BITS
  - WB_SEL_ALU / WB_SEL_LOAD / WB_SEL_PC4
  - funct3 load encodings FB_LB, FB_LH, FB_LW, FB_LBU, FB_LHU
- One sub-module, fb_load_align: a combinational extractor and extender (funct3, offset, raw word → formatted data, misaligned flag). ALU/branch logic reuses it for the store-side misalign check.

Test Plan:
1. Reset, then mem_valid=1, rd=5, wb_sel=ALU, alu=0x1234 → next cycle rf_we=1, waddr=5, wdata=0x1234; instret=1 after the following edge.
2. LB at addr 0x...03 with dmem_rdata=0x80FF_0000 → wdata=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at addr 0x...02 → 0x0000_80FF.
3. LW at addr 0x...02 → load_misaligned=1, rf_we=0, rf_wdata=0; instret still increments.
4. rd=0, rd_we=1, alu=0xDEAD → rf_we=0 and byp_valid=0; instret increments. JAL with rd=1, pc4=0x104 → wdata=0x104.
5. Alternate mem_valid 1,0,1 → rf_we pattern 1,0,1 on consecutive cycles; instret increments by 2 in total.
6. Assert reset while a valid load is in WB → rf_we=0 in that cycle and instret=0 afterwards. Also preload instret near 2^INSTRET_W-1 via a force and confirm it wraps to 0.
